// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state types and counter sizing for the request/grant arbiter slice
package arb_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_REQ  = 4'b0010,
    S_XFER = 4'b0100,
    S_REL  = 4'b1000
  } req_state_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_e;

  // Width able to hold 0..max_val; never narrower than one bit so a disabled limit still elaborates.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_wait_timer.sv
// rtl/arb_wait_timer.sv - saturating wait counter; terminal flags the increment that reaches TIMEOUT
module arb_wait_timer
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

  // TIMEOUT of zero means the limit can never be reached.
  assign terminal = (TIMEOUT != 0) && (count == LIMIT_M1);

endmodule

// File: rtl/arb_requester.sv
// rtl/arb_requester.sv - client agent: request, wait for grant, drive a counted bus burst, then back off
module arb_requester
  import arb_pkg::*;
#(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 15,
  parameter int GAP     = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             req,
  input  logic             gnt,
  output logic             bus_en,
  output logic             bus_last,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             done,
  output logic             err
);

  localparam int GW = cnt_width(GAP);
  localparam logic [GW-1:0] GAP_M1 = GW'(GAP - 1);

  req_state_e state, state_n;
  logic [LEN_W-1:0] len_q, len_n, beat_n, beat_inc;
  logic [GW-1:0] gap_q, gap_n;
  logic req_n, bus_en_n, bus_last_n, done_n, err_n;
  logic wait_clr, wait_en, wait_term;

  arb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
    .clock    (clock),
    .reset    (reset),
    .clear    (wait_clr),
    .enable   (wait_en),
    .terminal (wait_term)
  );

  assign cmd_ready = (state == S_IDLE);
  assign beat_inc  = beat_cnt + LEN_W'(1);

  always_comb begin
    state_n    = state;
    len_n      = len_q;
    beat_n     = beat_cnt;
    gap_n      = gap_q;
    req_n      = req;
    bus_en_n   = 1'b0;
    bus_last_n = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;
    wait_clr   = 1'b1;
    wait_en    = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_n = 1'b0;
        if (cmd_valid) begin
          len_n   = cmd_len;
          req_n   = 1'b1;
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        // Grant is checked first so it beats a timeout landing on the same edge.
        if (gnt) begin
          state_n    = S_XFER;
          bus_en_n   = 1'b1;
          beat_n     = '0;
          bus_last_n = (len_q == '0);
          done_n     = (len_q == '0);
        end else begin
          wait_clr = 1'b0;
          wait_en  = 1'b1;
          if (wait_term) begin
            err_n   = 1'b1;
            req_n   = 1'b0;
            gap_n   = '0;
            state_n = S_REL;
          end
        end
      end
      S_XFER: begin
        if (bus_last) begin
          req_n   = 1'b0;
          gap_n   = '0;
          state_n = S_REL;
        end else if (!gnt) begin
          req_n   = 1'b0;
          err_n   = 1'b1;
          gap_n   = '0;
          state_n = S_REL;
        end else begin
          bus_en_n   = 1'b1;
          beat_n     = beat_inc;
          bus_last_n = (beat_inc == len_q);
          done_n     = (beat_inc == len_q);
        end
      end
      S_REL: begin
        req_n = 1'b0;
        if (gap_q == GAP_M1) begin
          state_n = S_IDLE;
        end else begin
          gap_n = gap_q + GW'(1);
        end
      end
      default: begin
        req_n   = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      len_q    <= '0;
      gap_q    <= '0;
      req      <= 1'b0;
      bus_en   <= 1'b0;
      bus_last <= 1'b0;
      beat_cnt <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      len_q    <= len_n;
      gap_q    <= gap_n;
      req      <= req_n;
      bus_en   <= bus_en_n;
      bus_last <= bus_last_n;
      beat_cnt <= beat_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// tb/tb_arb_requester.sv - two requesters around a small arbiter model, directed vectors
module tb_arb_requester;
  import arb_pkg::*;

  localparam int LEN_W = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid_0 = 1'b0, cmd_valid_1 = 1'b0;
  logic [LEN_W-1:0] cmd_len_0 = '0, cmd_len_1 = '0;
  logic cmd_ready_0, req_0, gnt_0, bus_en_0, bus_last_0, done_0, err_0;
  logic cmd_ready_1, req_1, gnt_1, bus_en_1, bus_last_1, done_1, err_1;
  logic [LEN_W-1:0] beat_cnt_0, beat_cnt_1;
  logic block_0 = 1'b0;
  arb_state_e arb_state;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  always_ff @(posedge clock) begin
    if (reset) begin
      arb_state <= ARB_IDLE;
    end else begin
      case (arb_state)
        ARB_IDLE: if (req_0) arb_state <= ARB_GNT0; else if (req_1) arb_state <= ARB_GNT1;
        ARB_GNT0: if (!req_0) arb_state <= ARB_IDLE;
        ARB_GNT1: if (!req_1) arb_state <= ARB_IDLE;
        default:  arb_state <= ARB_IDLE;
      endcase
    end
  end

  assign gnt_0 = (arb_state == ARB_GNT0) && !block_0;
  assign gnt_1 = (arb_state == ARB_GNT1);

  arb_requester #(.LEN_W(LEN_W), .TIMEOUT(15), .GAP(1)) u_req_0 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid_0), .cmd_len(cmd_len_0),
    .cmd_ready(cmd_ready_0), .req(req_0), .gnt(gnt_0), .bus_en(bus_en_0),
    .bus_last(bus_last_0), .beat_cnt(beat_cnt_0), .done(done_0), .err(err_0)
  );

  arb_requester #(.LEN_W(LEN_W), .TIMEOUT(15), .GAP(1)) u_req_1 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid_1), .cmd_len(cmd_len_1),
    .cmd_ready(cmd_ready_1), .req(req_1), .gnt(gnt_1), .bus_en(bus_en_1),
    .bus_last(bus_last_1), .beat_cnt(beat_cnt_1), .done(done_1), .err(err_1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // {req, bus_en, bus_last, done, err, cmd_ready}
  function automatic logic [5:0] st0();
    return {req_0, bus_en_0, bus_last_0, done_0, err_0, cmd_ready_0};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    check_eq("rst_st0", st0(), 6'b000001);
    check_eq("rst_st1", {req_1, bus_en_1, bus_last_1, done_1, err_1, cmd_ready_1}, 6'b000001);
    check_eq("rst_beat", beat_cnt_0, 0);
    reset = 1'b0;
    tick();

    // single beat
    cmd_valid_0 = 1'b1; cmd_len_0 = 4'd0; tick(); cmd_valid_0 = 1'b0;
    check_eq("sb_e0", st0(), 6'b100000);
    tick(); check_eq("sb_e1", st0(), 6'b100000);
    tick(); check_eq("sb_e2", st0(), 6'b111100);
    check_eq("sb_beat", beat_cnt_0, 0);
    tick(); check_eq("sb_e3", st0(), 6'b000000);
    tick(); check_eq("sb_e4", st0(), 6'b000001);

    // four beats; a second command during REQ must be ignored
    tick();
    cmd_valid_0 = 1'b1; cmd_len_0 = 4'd3; tick();
    cmd_len_0 = 4'd0; tick(); cmd_valid_0 = 1'b0;
    check_eq("fb_e1", st0(), 6'b100000);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("fb_beat", beat_cnt_0, i);
      check_eq("fb_st", st0(), (i == 3) ? 6'b111100 : 6'b110000);
    end
    tick(); check_eq("fb_end", st0(), 6'b000000);
    tick(); check_eq("fb_rdy", st0(), 6'b000001);

    // contention: port 0 wins, port 1 follows after the gap
    tick();
    cmd_valid_0 = 1'b1; cmd_valid_1 = 1'b1; cmd_len_0 = 4'd1; cmd_len_1 = 4'd1;
    tick(); cmd_valid_0 = 1'b0; cmd_valid_1 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_eq("ct_en0", bus_en_0, (k == 2 || k == 3));
      check_eq("ct_en1", bus_en_1, (k == 7 || k == 8));
      check_eq("ct_excl", bus_en_0 & bus_en_1, 0);
      check_eq("ct_done1", done_1, k == 8);
      check_eq("ct_last1", bus_last_1, k == 8);
      if (k == 7 || k == 8) check_eq("ct_beat1", beat_cnt_1, k - 7);
    end
    check_eq("ct_rdy", {cmd_ready_0, cmd_ready_1}, 2'b11);
    check_eq("ct_err1", err_1, 0);

    // timeout with grant blocked
    tick(); block_0 = 1'b1;
    cmd_valid_0 = 1'b1; cmd_len_0 = 4'd0; tick(); cmd_valid_0 = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check_eq("to_err", err_0, k == 15);
      check_eq("to_req", req_0, k < 15);
    end
    tick(); check_eq("to_after", st0(), 6'b000001);
    block_0 = 1'b0;

    // grant loss on beat 1 of four
    tick();
    cmd_valid_0 = 1'b1; cmd_len_0 = 4'd3; tick(); cmd_valid_0 = 1'b0;
    tick(); tick(); tick();
    check_eq("gl_b1", {bus_en_0, beat_cnt_0}, {1'b1, 4'd1});
    block_0 = 1'b1; tick();
    check_eq("gl_drop", st0(), 6'b000010);
    block_0 = 1'b0; tick();
    check_eq("gl_rdy", st0(), 6'b000001);

    // reset on beat 2, then a normal command
    tick();
    cmd_valid_0 = 1'b1; cmd_len_0 = 4'd3; tick(); cmd_valid_0 = 1'b0;
    tick(); tick(); tick(); tick();
    check_eq("rx_b2", beat_cnt_0, 2);
    reset = 1'b1; tick(); reset = 1'b0;
    check_eq("rx_st", st0(), 6'b000001);
    cmd_valid_0 = 1'b1; cmd_len_0 = 4'd0; tick(); cmd_valid_0 = 1'b0;
    tick(); tick(); check_eq("rx_next", st0(), 6'b111100);
    tick(); tick(); check_eq("rx_rdy", st0(), 6'b000001);

    // maximum length: beat_cnt runs to all-ones without wrapping
    tick();
    cmd_valid_0 = 1'b1; cmd_len_0 = 4'hf; tick(); cmd_valid_0 = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      check_eq("ml_beat", beat_cnt_0, i);
      check_eq("ml_last", {bus_en_0, bus_last_0}, {1'b1, i == 15});
    end
    tick(); check_eq("ml_end", {req_0, bus_en_0, bus_last_0}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
Client-side agent for the two-port request/grant arbiter. It accepts a burst command from local logic, raises `req`, waits for `gnt`, and drives a bus-enable window of exactly the commanded number of beats while holding `req`. It then releases `req` for a guaranteed gap so the other requester can win arbitration. One instance sits on each arbiter port (`req_0`/`gnt_0`, `req_1`/`gnt_1`).

Parameters:
LEN_W, 4, width of the burst-length field; the command encodes beats = `cmd_len` + 1 (1..2^LEN_W).
TIMEOUT, 15, maximum cycles spent in REQ with `gnt` low before abort; 0 disables the timeout.
GAP, 1, cycles `req` is held low in REL after every burst or abort (>=1).

Ports:
clock  input  1  system clock; all logic on the posedge.
reset  input  1  synchronous, active-high reset.
cmd_valid  input  1  burst command present.
cmd_len  input  LEN_W  beats minus one.
cmd_ready  output  1  high only in IDLE; the command is accepted on `cmd_valid && cmd_ready`.
req  output  1  request to the arbiter; registered.
gnt  input  1  grant from the arbiter; registered at the arbiter, sampled directly.
bus_en  output  1  owns the shared bus this cycle (one beat per cycle).
bus_last  output  1  final beat of the burst; only asserted together with `bus_en`.
beat_cnt  output  LEN_W  index of the current beat, 0..`cmd_len`.
done  output  1  one-cycle pulse, coincident with `bus_last`.
err  output  1  one-cycle pulse on timeout or grant loss.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All outputs are registered except `cmd_ready`, which is a decode of the state register.
- Reset values: state IDLE; `req`, `bus_en`, `bus_last`, `done`, `err` = 0; `beat_cnt` = 0; wait counter = 0; `cmd_ready` = 1 after reset.
- State encoding: one-hot, 4 states: IDLE, REQ, XFER, REL.
- IDLE:
  - `req` = 0.
  - On `cmd_valid` at edge E: latch `cmd_len`, go to REQ, `req` = 1 from E.
- REQ:
  - `req` = 1.
  - If `gnt` = 1 at an edge: go to XFER, `bus_en` = 1, `beat_cnt` = 0, clear the wait counter.
  - Otherwise increment the wait counter.
  - If TIMEOUT != 0 and the wait counter reaches TIMEOUT: pulse `err`, drop `req`, go to REL.
- XFER:
  - `req` = 1 and `bus_en` = 1 for exactly `cmd_len` + 1 consecutive cycles; `beat_cnt` increments each cycle.
  - On the beat where `beat_cnt` == latched `cmd_len`: `bus_last` = 1 and `done` = 1.
  - At the next edge: `req`, `bus_en`, `bus_last` → 0; go to REL.
  - `cmd_len` = 0 gives a single beat with `bus_last` and `done` in that same cycle.
- Grant loss: if `gnt` is sampled 0 in XFER before the last beat, deassert `bus_en` and `req` at that edge, pulse `err` (no `done`), go to REL.
- REL: `req` = 0 for GAP cycles, then IDLE. This gap lets the arbiter return to its IDLE state and serve the peer.
- Latency, uncontended: command accepted at edge 0 → arbiter samples `req` at edge 1 → `gnt` sampled at edge 2 → first `bus_en` after edge 2.
- Burst cost: total cycles from acceptance to the next `cmd_ready` = 2 + beats + GAP.
- `gnt` in IDLE or REL is ignored: no state change, no `err`.
- `cmd_valid` outside IDLE is ignored; it must not be latched.
- Wait counter: width $clog2(TIMEOUT+1); saturates and never wraps.
- `beat_cnt`: LEN_W bits; with `cmd_len` = all-ones it reaches 2^LEN_W−1 as the last beat and never wraps inside a burst.
- Reset mid-operation, in any state: at that edge `req` and `bus_en` → 0, state → IDLE, no `done`/`err` pulse.
- Simultaneous timeout edge and `gnt` = 1: grant wins; go to XFER, no `err`.

Decomposition:
- Package arb_pkg:
  - one-hot state typedef for the requester states;
  - shared state typedef for the arbiter's IDLE/GNT0/GNT1 states;
  - a `clog2`-based width helper constant for the wait counter.
- Optional sub-module arb_wait_timer: a saturating counter with clear, enable and a terminal flag, parameterised by TIMEOUT.

Test Plan:
- Single beat: `gnt` tied to `req` delayed by one cycle; `cmd_len`=0 accepted at edge 0 → `bus_en`/`bus_last`/`done` high for 1 cycle after edge 2; `req` low after edge 3; `cmd_ready` high again after edge 4 (GAP=1).
- Four-beat burst: `cmd_len`=3 → `beat_cnt` 0,1,2,3 on consecutive cycles; `bus_last` only at 3; `req` continuously high from acceptance to the edge after the last beat.
- Contention: two instances plus the arbiter, both commanded `cmd_len`=1 in the same cycle → port 0 bursts first; port 1's `bus_en` starts only after port 0's REL gap; `bus_en` is never high on both ports in the same cycle.
- Timeout: TIMEOUT=15 with `gnt` held 0 → `err` pulses exactly 15 cycles after REQ entry; `req` drops at the same edge; then `cmd_ready` rises.
- Grant loss: force `gnt`=0 on beat 1 of a 4-beat burst → `bus_en` drops at that edge, `err`=1, `done` never asserts.
- Reset mid-XFER: assert `reset` on beat 2 → after that edge `req`=`bus_en`=0, `cmd_ready`=1, no pulses; the next command completes normally.
